fpcvt_arb: RTL

FPCVT_ARB -- requirements
Module: fpcvt_arb

---
 rtl/fpcvt_pkg.sv | 18 +
 rtl/fpcvt_core.sv | 57 +++++
 rtl/fpcvt_arb.sv | 98 +++++++++
 3 files changed

// File: rtl/fpcvt_pkg.sv
// Shared widths and the 8-bit mini-float result type for the sample converter.
package fpcvt_pkg;

   localparam int unsigned IN_W    = 12;
   localparam int unsigned FP_W    = 8;
   localparam int unsigned EXP_W   = 3;
   localparam int unsigned SIG_W   = 4;
   localparam int unsigned LZ_W    = 4;
   localparam int unsigned NORM_LZ = IN_W - SIG_W;
   localparam int unsigned EXP_MAX = (1 << EXP_W) - 1;

   typedef struct packed {
      logic             sign;
      logic [EXP_W-1:0] exp;
      logic [SIG_W-1:0] sig;
   } fp_t;

endpackage

// File: rtl/fpcvt_core.sv
// Combinational 12-bit two's-complement to sign/3-bit exp/4-bit significand converter
// with half-up rounding on magnitude and saturation at the top of the range.
module fpcvt_core
   import fpcvt_pkg::*;
(
   input  logic [IN_W-1:0] i_data,
   output fp_t             o_fp_c
);

   logic [IN_W-1:0] w_mag;
   logic [IN_W-1:0] w_norm;
   logic [LZ_W-1:0] w_lz;
   logic [EXP_W:0]  w_exp;
   logic [SIG_W:0]  w_sig;

   // Magnitude; the most negative input has no positive twin and clamps to max
   always_comb begin
      w_mag = i_data;
      if (i_data[IN_W-1]) begin
         if (i_data == {1'b1, {(IN_W-1){1'b0}}})
            w_mag = {1'b0, {(IN_W-1){1'b1}}};
         else
            w_mag = ~i_data + IN_W'(1);
      end
   end

   always_comb begin
      w_lz = LZ_W'(IN_W);
      for (int unsigned i = 0; i < IN_W; i++) begin
         if (w_mag[i]) w_lz = LZ_W'(IN_W - 1 - i);
      end
   end

   always_comb begin
      w_norm = w_mag << w_lz;
      w_exp  = '0;
      w_sig  = '0;
      if (w_lz >= LZ_W'(NORM_LZ)) begin
         w_sig = {1'b0, w_mag[SIG_W-1:0]};
      end else begin
         w_exp = (EXP_W+1)'(NORM_LZ) - (EXP_W+1)'(w_lz);
         w_sig = {1'b0, w_norm[IN_W-1 -: SIG_W]} + (SIG_W+1)'(w_norm[IN_W-SIG_W-1]);
         if (w_sig[SIG_W]) begin
            w_sig = (SIG_W+1)'(1) << (SIG_W - 1);
            w_exp = w_exp + (EXP_W+1)'(1);
         end
         if (w_exp > (EXP_W+1)'(EXP_MAX)) begin
            w_exp = (EXP_W+1)'(EXP_MAX);
            w_sig = {1'b0, {SIG_W{1'b1}}};
         end
      end
      o_fp_c.sign = i_data[IN_W-1];
      o_fp_c.exp  = w_exp[EXP_W-1:0];
      o_fp_c.sig  = w_sig[SIG_W-1:0];
   end

endmodule

// File: rtl/fpcvt_arb.sv
// Round-robin arbiter feeding a two-stage pipeline (sample register, result register)
// around the combinational converter; one result per cycle under no backpressure.
module fpcvt_arb
   import fpcvt_pkg::*;
#(
   parameter  int unsigned NREQ = 4,
   localparam int unsigned IDW  = $clog2(NREQ)
)
(
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic [NREQ-1:0]      req_valid,
   input  logic [NREQ*IN_W-1:0] req_data,
   output logic [NREQ-1:0]      req_ready,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [FP_W-1:0]      out_fp,
   output logic [IDW-1:0]       out_id
);

   logic            r_a_valid;
   logic [IN_W-1:0] r_a_data;
   logic [IDW-1:0]  r_a_id;
   logic            r_b_valid;
   fp_t             r_b_fp;
   logic [IDW-1:0]  r_b_id;
   logic [IDW-1:0]  r_ptr;

   logic            w_b_load;
   logic            w_a_acc;
   logic            w_gnt_any;
   logic            w_take;
   logic [IDW-1:0]  w_gnt_id;
   logic [IN_W-1:0] w_gnt_data;
   fp_t             w_fp;

   // out_ready reaches the request side only through the stage-B load term
   assign w_b_load = !r_b_valid || out_ready;
   assign w_a_acc  = !r_a_valid || w_b_load;

   // First valid requester at or after the pointer, wrapping modulo NREQ
   always_comb begin
      logic [IDW-1:0] idx;
      w_gnt_any = 1'b0;
      w_gnt_id  = r_ptr;
      for (int unsigned k = 0; k < NREQ; k++) begin
         idx = r_ptr + IDW'(k);
         if (!w_gnt_any && req_valid[idx]) begin
            w_gnt_any = 1'b1;
            w_gnt_id  = idx;
         end
      end
   end

   assign w_take     = w_a_acc && w_gnt_any;
   assign w_gnt_data = req_data[32'(w_gnt_id) * IN_W +: IN_W];

   always_comb begin
      req_ready = '0;
      if (rst_n && w_take) req_ready[w_gnt_id] = 1'b1;
   end

   fpcvt_core u_core (
      .i_data (r_a_data),
      .o_fp_c (w_fp)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_a_valid <= 1'b0;
         r_a_data  <= '0;
         r_a_id    <= '0;
         r_b_valid <= 1'b0;
         r_b_fp    <= '0;
         r_b_id    <= '0;
         r_ptr     <= '0;
      end else begin
         if (w_b_load) begin
            r_b_valid <= r_a_valid;
            if (r_a_valid) begin
               r_b_fp <= w_fp;
               r_b_id <= r_a_id;
            end
         end
         if (w_a_acc) r_a_valid <= w_gnt_any;
         if (w_take) begin
            r_a_data <= w_gnt_data;
            r_a_id   <= w_gnt_id;
            r_ptr    <= w_gnt_id + IDW'(1);
         end
      end
   end

   assign out_valid = r_b_valid;
   assign out_fp    = r_b_fp;
   assign out_id    = r_b_id;

endmodule
